// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared types and constants for the row-wise softmax unit.
package softmax_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAX  = 3'd1,
    EXP  = 3'd2,
    DIV  = 3'd3,
    NORM = 3'd4
  } state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_SEQ_LEN    = 64;
  localparam int DEF_FRAC_BITS  = 14;
  localparam int LOG2E_Q        = 23637;

  // round(2**14 * 2**(-k/16)): fractional part of the base-2 exponent
  function automatic logic [14:0] exp_lut(input logic [3:0] k);
    case (k)
      4'd0:    exp_lut = 15'd16384;
      4'd1:    exp_lut = 15'd15689;
      4'd2:    exp_lut = 15'd15024;
      4'd3:    exp_lut = 15'd14387;
      4'd4:    exp_lut = 15'd13777;
      4'd5:    exp_lut = 15'd13193;
      4'd6:    exp_lut = 15'd12634;
      4'd7:    exp_lut = 15'd12098;
      4'd8:    exp_lut = 15'd11585;
      4'd9:    exp_lut = 15'd11094;
      4'd10:   exp_lut = 15'd10624;
      4'd11:   exp_lut = 15'd10173;
      4'd12:   exp_lut = 15'd9742;
      4'd13:   exp_lut = 15'd9329;
      4'd14:   exp_lut = 15'd8933;
      default: exp_lut = 15'd8555;
    endcase
  endfunction

endpackage

// File: rtl/softmax_recip_div.sv
// rtl/softmax_recip_div.sv - fixed-latency restoring divider for the row reciprocal.
// done_o and quotient_o are combinational during the final iteration so the caller can capture them on that edge.
module softmax_recip_div #(
  parameter int QW = 29,
  parameter int SW = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [QW-1:0] dividend_i,
  input  logic [SW-1:0] divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [QW-1:0] quotient_o
);

  localparam int CW = $clog2(QW + 1);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] rem_q;
  logic [SW-1:0] dvs_q;
  logic [QW-1:0] quo_q;

  logic [SW+1:0] partial;
  logic [SW+1:0] diff;
  logic          ge;
  logic [SW-1:0] rem_d;
  logic [QW-1:0] quo_d;

  always_comb begin
    partial = {1'b0, rem_q, quo_q[QW-1]};
    diff    = partial - {2'b00, dvs_q};
    ge      = ~diff[SW+1];
    rem_d   = ge ? diff[SW-1:0] : partial[SW-1:0];
    quo_d   = {quo_q[QW-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(QW);
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      quo_q  <= dividend_i;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == CW'(1));
  assign quotient_o = quo_d;

endmodule

// File: rtl/softmax_row_unit.sv
// rtl/softmax_row_unit.sv - row-wise fixed-point softmax over a SEQ_LEN x SEQ_LEN score matrix.
// Per row: max search, base-2 exp via LUT and shift, one reciprocal divide, normalise.
module softmax_row_unit
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SEQ_LEN    = DEF_SEQ_LEN,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0] scores_flat,
  output logic                                  done,
  output logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0] softmax_scores_flat,
  output logic [2:0]                            debug_state
);

  localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int EW = FRAC_BITS + 1;
  localparam int SW = EW + IW;
  localparam int QW = 2 * FRAC_BITS + 1;
  localparam int PW = DATA_WIDTH + 19;
  localparam logic [IW-1:0] LAST = IW'(SEQ_LEN - 1);
  localparam logic signed [DATA_WIDTH-1:0] MX_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] LOG2E_S = PW'(LOG2E_Q);
  localparam logic [QW-1:0] DIVIDEND = {1'b1, {(2*FRAC_BITS){1'b0}}};

  state_t                       state_q, state_d;
  logic [IW-1:0]                i_q, i_d, j_q, j_d;
  logic signed [DATA_WIDTH-1:0] mx_q, mx_d;
  logic [SW-1:0]                sum_q, sum_d;
  logic [EW-1:0]                recip_q, recip_d;
  logic                         done_q, done_d;
  logic [EW-1:0]                ebuf [SEQ_LEN];

  logic signed [DATA_WIDTH-1:0] s_ij;
  logic signed [DATA_WIDTH:0]   d;
  logic signed [PW-1:0]         prod, u;
  logic [PW-1:0]                n;
  logic [EW-1:0]                lut_k, e;
  logic [2*EW-1:0]              nprod;
  logic                         ebuf_we, out_we, div_start, div_busy, div_done;
  logic [QW-1:0]                div_q;

  assign s_ij = scores_flat[(int'(i_q) * SEQ_LEN + int'(j_q)) * DATA_WIDTH +: DATA_WIDTH];

  // e = 2**(-u), u = (mx - s) * log2(e): integer part shifts, top 4 fraction bits index the LUT
  always_comb begin
    d     = {s_ij[DATA_WIDTH-1], s_ij} - {mx_q[DATA_WIDTH-1], mx_q};
    prod  = PW'(d) * LOG2E_S;
    u     = -(prod >>> FRAC_BITS);
    n     = u >> FRAC_BITS;
    lut_k = EW'(exp_lut(u[FRAC_BITS-1 -: 4]));
    e     = (n > PW'(FRAC_BITS)) ? '0 : lut_k >> n;
    nprod = (2*EW)'(ebuf[j_q]) * (2*EW)'(recip_q);
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    mx_d      = mx_q;
    sum_d     = sum_q;
    recip_d   = recip_q;
    done_d    = done_q;
    ebuf_we   = 1'b0;
    out_we    = 1'b0;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (!start) begin
          done_d = 1'b0;
        end else if (!done_q) begin
          i_d     = '0;
          j_d     = '0;
          mx_d    = MX_MIN;
          sum_d   = '0;
          state_d = MAX;
        end
      end
      MAX: begin
        if (s_ij > mx_q) mx_d = s_ij;
        j_d = j_q + 1'b1;
        if (j_q == LAST) begin
          j_d     = '0;
          state_d = EXP;
        end
      end
      EXP: begin
        ebuf_we = 1'b1;
        sum_d   = sum_q + SW'(e);
        j_d     = j_q + 1'b1;
        if (j_q == LAST) begin
          j_d     = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        div_start = !div_busy;
        if (div_done) begin
          recip_d = div_q[EW-1:0];
          state_d = NORM;
        end
      end
      NORM: begin
        out_we = 1'b1;
        j_d    = j_q + 1'b1;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            i_d     = i_q + 1'b1;
            mx_d    = MX_MIN;
            sum_d   = '0;
            state_d = MAX;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      mx_q    <= '0;
      sum_q   <= '0;
      recip_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      mx_q    <= mx_d;
      sum_q   <= sum_d;
      recip_q <= recip_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ebuf_we) ebuf[j_q] <= e;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      softmax_scores_flat <= '0;
    end else if (out_we) begin
      softmax_scores_flat[(int'(i_q) * SEQ_LEN + int'(j_q)) * DATA_WIDTH +: DATA_WIDTH]
        <= DATA_WIDTH'(nprod >> FRAC_BITS);
    end
  end

  softmax_recip_div #(
    .QW(QW),
    .SW(SW)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .dividend_i(DIVIDEND),
    .divisor_i (sum_q),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quotient_o(div_q)
  );

  assign done        = done_q;
  assign debug_state = state_q;

endmodule
